mux_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 31 +++
 rtl/mux_rr_arbiter_if.sv | 29 ++
 rtl/mux2.sv | 11 +
 rtl/mux_n.sv | 31 +++
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types, defaults and the circular first-set search for mux_rr_arbiter.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_DEF        = 4;
  localparam int DW_DEF       = 8;
  localparam int MAX_HOLD_DEF = 8;
  localparam int SEL_W        = $clog2(N_DEF);

  // First set bit of req_v scanning ptr_v, ptr_v+1, ... wrapping at n (n <= 16).
  function automatic int rr_pick(input logic [15:0] req_v, input int ptr_v, input int n);
    int  pick;
    bit  found;
    int  idx;
    pick  = 0;
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idx = (ptr_v + i) % n;
      if (i < n && !found && req_v[idx[3:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bundle of mux_rr_arbiter: request/release, data lanes, grant and muxed data.
interface mux_rr_arbiter_if
  import mux_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int DW = DW_DEF
);
  localparam int SW = $clog2(N);

  logic [N-1:0]    req;
  logic [N-1:0]    done;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    grant;
  logic [SW-1:0]   sel;
  logic            valid;
  logic [DW-1:0]   data_out;
  logic            expired;

  modport master (
    output req, done, data_in,
    input  grant, sel, valid, data_out, expired
  );

  modport slave (
    input  req, done, data_in,
    output grant, sel, valid, data_out, expired
  );

endinterface

// File: rtl/mux2.sv
// 2:1 MUX primitive, W bits wide: y = s ? b : a.
module mux2 #(
  parameter int W = 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         s,
  output logic [W-1:0] y
);
  assign y = s ? b : a;
endmodule

// File: rtl/mux_n.sv
// N:1 DW-wide mux tree of mux2 cells, log2(N) levels deep; root level decodes the select MSB.
module mux_n #(
  parameter int N  = 4,
  parameter int DW = 8
) (
  input  logic [$clog2(N)-1:0] sel,
  input  logic [N*DW-1:0]      data_in,
  output logic [DW-1:0]        data_out
);
  localparam int SW = $clog2(N);

  // Heap-ordered nodes: node k has children 2k+1 / 2k+2, lane i sits at leaf N-1+i.
  logic [DW-1:0] node [2*N-1];

  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign node[N-1+i] = data_in[i*DW +: DW];
  end

  for (genvar k = 0; k < N-1; k++) begin : g_cell
    localparam int D = $clog2(k + 2) - 1;
    mux2 #(.W(DW)) u_mux2 (
      .a (node[2*k+1]),
      .b (node[2*k+2]),
      .s (sel[SW-1-D]),
      .y (node[k])
    );
  end

  assign data_out = node[0];

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of an N:1 mux tree; optional grant timeout
// is enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input logic             clk,
  input logic             reset,
  mux_rr_arbiter_if.slave bus
);
  localparam int SW = $clog2(N);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [SW-1:0] winner;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          expired_q, expired_d;
  logic          release_hit;
  logic          timeout_hit;
  logic [DW-1:0] lane;

  assign winner      = SW'(rr_pick(16'(bus.req), int'(ptr_q), N));
  assign release_hit = (state_q == GRANT) && (bus.done[sel_q] || !bus.req[sel_q]);

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;

  // A release in the same cycle as the hold limit wins, so expired stays low.
  always_comb begin
    hold_d      = '0;
    timeout_hit = 1'b0;
    if (state_q == GRANT) begin
      hold_d      = hold_q + HW'(1);
      timeout_hit = !release_hit && (hold_q == HW'(MAX_HOLD - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    expired_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          grant_d = N'(1) << winner;
          sel_d   = winner;
          valid_d = 1'b1;
        end else begin
          grant_d = '0;
          sel_d   = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_hit || timeout_hit) begin
          state_d   = IDLE;
          grant_d   = '0;
          sel_d     = '0;
          valid_d   = 1'b0;
          ptr_d     = sel_q + SW'(1);
          expired_d = timeout_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together.
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      expired_q <= expired_d;
    end
  end

  mux_n #(.N(N), .DW(DW)) u_mux_n (
    .sel      (sel_q),
    .data_in  (bus.data_in),
    .data_out (lane)
  );

  assign bus.grant    = grant_q;
  assign bus.sel      = sel_q;
  assign bus.valid    = valid_q;
  assign bus.expired  = expired_q;
  assign bus.data_out = valid_q ? lane : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table, hand sequences, randomized model compare.
module tb_mux_rr_arbiter;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.N(N), .DW(DW)) bus ();

  mux_rr_arbiter #(.N(N), .DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] lanes [N];

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] grant;
    int           sel;
    logic         valid;
  } vec_t;

  // Reference model: who owns the lane, where the scan starts, how long it has held.
  int m_owner;
  int m_ptr;
  int m_hold;
  bit m_expired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) bus.data_in[i*DW +: DW] = lanes[i];
  endtask

  task automatic check_outputs(input string tag, input logic [N-1:0] g, input int s,
                               input logic v, input logic e);
    logic [DW-1:0] d;
    d = v ? lanes[s] : '0;
    check($sformatf("%s.grant", tag),    32'(bus.grant),    32'(g));
    check($sformatf("%s.sel", tag),      32'(bus.sel),      32'(s));
    check($sformatf("%s.valid", tag),    32'(bus.valid),    32'(v));
    check($sformatf("%s.data_out", tag), 32'(bus.data_out), 32'(d));
    check($sformatf("%s.expired", tag),  32'(bus.expired),  32'(e));
  endtask

  task automatic model_step(input bit rst, input logic [N-1:0] r, input logic [N-1:0] d);
    m_expired = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        if (m_owner < 0 && r[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
      end
      m_hold = 0;
    end else if (d[m_owner] || !r[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else if (TIMEOUT_EN && m_hold == MAX_HOLD - 1) begin
      m_expired = 1'b1;
      m_ptr     = (m_owner + 1) % N;
      m_owner   = -1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0] g;
    g = (m_owner < 0) ? '0 : N'(1) << m_owner;
    check_outputs(tag, g, (m_owner < 0) ? 0 : m_owner, m_owner >= 0, m_expired);
  endtask

  initial begin
    vec_t vecs [27];
    int   cycles;

    vecs = '{
      '{4'hF, 4'h0, 4'h1, 0, 1'b1}, '{4'hF, 4'h0, 4'h1, 0, 1'b1}, '{4'hF, 4'h1, 4'h0, 0, 1'b0},
      '{4'hF, 4'h0, 4'h2, 1, 1'b1}, '{4'hF, 4'h0, 4'h2, 1, 1'b1}, '{4'hF, 4'h2, 4'h0, 0, 1'b0},
      '{4'hF, 4'h0, 4'h4, 2, 1'b1}, '{4'hF, 4'h0, 4'h4, 2, 1'b1}, '{4'hF, 4'h4, 4'h0, 0, 1'b0},
      '{4'hF, 4'h0, 4'h8, 3, 1'b1}, '{4'hF, 4'h0, 4'h8, 3, 1'b1}, '{4'hF, 4'h8, 4'h0, 0, 1'b0},
      '{4'hF, 4'h0, 4'h1, 0, 1'b1}, '{4'hF, 4'h1, 4'h0, 0, 1'b0},
      '{4'h2, 4'h0, 4'h2, 1, 1'b1}, '{4'hF, 4'h4, 4'h2, 1, 1'b1}, '{4'hD, 4'h0, 4'h0, 0, 1'b0},
      '{4'h4, 4'h0, 4'h4, 2, 1'b1}, '{4'h4, 4'h4, 4'h0, 0, 1'b0},
      '{4'h5, 4'h0, 4'h1, 0, 1'b1}, '{4'h5, 4'h1, 4'h0, 0, 1'b0},
      '{4'h5, 4'h0, 4'h4, 2, 1'b1}, '{4'h5, 4'h4, 4'h0, 0, 1'b0},
      '{4'h0, 4'hF, 4'h0, 0, 1'b0}, '{4'h0, 4'h0, 4'h0, 0, 1'b0},
      '{4'hF, 4'h0, 4'h8, 3, 1'b1}, '{4'h0, 4'h0, 4'h0, 0, 1'b0}
    };

    lanes = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    drive_lanes();
    reset    = 1'b1;
    bus.req  = 4'hF;
    bus.done = 4'h0;

    // Reset held two cycles with every requester asking.
    tick();
    tick();
    check_outputs("reset", 4'h0, 0, 1'b0, 1'b0);
    reset = 1'b0;

    // Rotation, skip/wrap, data path, ignored done, req drop.
    for (int i = 0; i < 27; i++) begin
      bus.req  = vecs[i].req;
      bus.done = vecs[i].done;
      tick();
      check_outputs($sformatf("vec%0d", i), vecs[i].grant, vecs[i].sel, vecs[i].valid, 1'b0);
    end

    // Reset in the middle of a grant to requester 2 brings ptr back to 0.
    bus.req = 4'h2; bus.done = 4'h0; tick();
    bus.req = 4'hF; bus.done = 4'h2; tick();
    bus.done = 4'h0; tick();
    check_outputs("pre_reset", 4'h4, 2, 1'b1, 1'b0);
    reset = 1'b1; tick();
    check_outputs("mid_reset", 4'h0, 0, 1'b0, 1'b0);
    reset = 1'b0; tick();
    check_outputs("post_reset", 4'h1, 0, 1'b1, 1'b0);
    bus.done = 4'h1; tick();
    bus.done = 4'h0; bus.req = 4'h0; tick();

    // Requester 0 holds on with no done.
    reset = 1'b1; tick();
    reset = 1'b0; bus.req = 4'h1; tick();
    cycles = 0;
    while (bus.valid === 1'b1 && cycles < 25) begin
      check($sformatf("hold%0d.expired", cycles), 32'(bus.expired), 32'(0));
      cycles++;
      tick();
    end
    if (TIMEOUT_EN) begin
      check("timeout.cycles", 32'(cycles), 32'(MAX_HOLD));
      check("timeout.expired", 32'(bus.expired), 32'(1));
      tick();
      check("timeout.expired_clear", 32'(bus.expired), 32'(0));
    end else begin
      check("hold.cycles", 32'(cycles), 32'(25));
      check("hold.valid", 32'(bus.valid), 32'(1));
    end
    bus.req = 4'h0; tick();

    // Randomized traffic against the model.
    reset = 1'b1; tick();
    model_step(1'b1, '0, '0);
    reset = 1'b0;
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++) begin
        bus.req[i]  = ($urandom_range(0, 3) != 0);
        bus.done[i] = ($urandom_range(0, 7) == 0);
        lanes[i]    = DW'($urandom);
      end
      drive_lanes();
      tick();
      model_step(reset, bus.req, bus.done);
      check_model($sformatf("rand%0d", c));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
